univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the fixed serial-in chain.
- Modes: hold, shift left/right, parallel load, rotate left/right, arithmetic shift right.
- Two ways to use it: single-step (one op per enabled cycle) and burst (one `start` runs a counted sequence of ops with busy/done handshake).
- Serves as the general-purpose serialiser/deserialiser and shifter for lab datapaths.

Parameters:
- N, 8, register width in bits (N >= 2).
- CW, 4, width of burst count input; max burst = 2^CW-1.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-high reset.
- en  input  1  single-step enable; used only in IDLE.
- mode  input  3  operation select (encoding below).
- sin_l  input  1  serial bit entering q[0] on shift left.
- sin_r  input  1  serial bit entering q[N-1] on shift right.
- d  input  N  parallel load data.
- start  input  1  begin burst; sampled only in IDLE.
- cnt  input  CW  burst length in operations.
- q  output  N  register contents.
- sout_l  output  1  q[N-1] (combinational from q).
- sout_r  output  1  q[0] (combinational from q).
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset: clr=1 at a rising edge forces q=0, busy=0, done=0, FSM=IDLE, internal count=0.
  - clr overrides every other input, including mid-burst.
  - An aborted burst never produces done.
- Mode encoding, applied per operation:
  - 000 hold.
  - 001 shl: q <= {q[N-2:0], sin_l}.
  - 010 shr: q <= {sin_r, q[N-1:1]}.
  - 011 load: q <= d.
  - 100 rotl: q <= {q[N-2:0], q[N-1]}.
  - 101 rotr: q <= {q[0], q[N-1:1]}.
  - 110 asr: q <= {q[N-1], q[N-1:1]}.
  - 111 reserved; behaves as hold.
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - start=1: latch mode and cnt; q unchanged this edge; start has priority over en.
    - latched cnt=0, or latched mode in {000, 111} → DONE.
    - latched mode=011 → effective count forced to 1; → BURST.
    - otherwise → BURST.
  - start=0, en=1: perform one op per live mode; result visible after the edge (latency 1).
  - start=0, en=0: hold.
- BURST:
  - busy=1.
  - On each edge, perform the latched op using live sin_l/sin_r/d, then decrement the count.
  - On the edge that performs the last op → DONE.
  - en, start, mode, cnt are ignored.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next edge → IDLE; start is ignored in this cycle.
- Timing: start sampled at edge E0 with cnt=K>0 gives:
  - ops on edges E1..EK;
  - busy high from after E0 until after EK;
  - done high during the cycle after EK;
  - next start accepted at EK+2.
- cnt > N is legal; ops simply continue (e.g. shl with sin_l=0 clears q).
- Outputs are all registered except sout_l/sout_r.
- No X propagation from unused inputs.

Test Plan:
1. Reset: drive clr=1 for 1 edge with arbitrary q → q=0x00, busy=0, done=0, sout_l=0, sout_r=0.
2. Single-step sequence, N=8:
   - load d=0xA5, en=1 → q=0xA5;
   - then shl with sin_l=1 → 0x4B;
   - then shr with sin_r=0 → 0x25;
   - then en=0 → stays 0x25.
3. Burst rotl from q=0x81, start with cnt=3:
   - busy=1 for 3 cycles;
   - q after E3=0x0C;
   - done=1 exactly one cycle;
   - start pulsed at E1 is ignored.
4. Arithmetic shift from q=0x80:
   - single-step asr → 0xC0;
   - then burst asr cnt=7 → 0xFF;
   - then burst shr cnt=10 with sin_r=0 → 0x00.
5. Abort: burst shl cnt=10 from 0xFF with sin_l=0, clr=1 at E4:
   - q=0x00, busy=0, no done pulse;
   - a new start at the next edge is accepted.
6. Degenerate bursts:
   - cnt=0 → q unchanged, done pulses at the cycle after E0;
   - mode=011 with cnt=9 → single load, done after E1;
   - mode=111 with en=1 → q unchanged.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal N-bit shift register: hold, shift, load, rotate and arithmetic shift,
// usable one op per enabled cycle or as a counted burst with busy/done handshake.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | single-step ops on en; start latches mode/cnt for a burst
//   BURST | latched op applied every edge, count runs down to one
//   DONE  | one-cycle completion pulse; start ignored
module univ_shift_reg #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic          sin_l,
  input  logic          sin_r,
  input  logic [N-1:0]  d,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  output logic [N-1:0]  q,
  output logic          sout_l,
  output logic          sout_r,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_RSVD = 3'b111;

  state_t        state, state_nxt;
  logic [N-1:0]  q_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [2:0]    mode_lat, mode_lat_nxt;

  function automatic logic [N-1:0] apply_op(
    input logic [2:0]   op,
    input logic [N-1:0] cur,
    input logic         sl,
    input logic         sr,
    input logic [N-1:0] din
  );
    logic [N-1:0] res;
    res = cur;
    case (op)
      M_SHL:   res = {cur[N-2:0], sl};
      M_SHR:   res = {sr, cur[N-1:1]};
      M_LOAD:  res = din;
      M_ROTL:  res = {cur[N-2:0], cur[N-1]};
      M_ROTR:  res = {cur[0], cur[N-1:1]};
      M_ASR:   res = {cur[N-1], cur[N-1:1]};
      default: res = cur;
    endcase
    return res;
  endfunction

  always_comb begin
    state_nxt    = state;
    q_nxt        = q;
    count_nxt    = count;
    mode_lat_nxt = mode_lat;
    case (state)
      IDLE: begin
        if (start) begin
          mode_lat_nxt = mode;
          // a burst load only ever needs one op, whatever cnt says
          count_nxt    = (mode == M_LOAD) ? CW'(1) : cnt;
          if (cnt == '0 || mode == M_HOLD || mode == M_RSVD)
            state_nxt = DONE;
          else
            state_nxt = BURST;
        end else if (en) begin
          q_nxt = apply_op(mode, q, sin_l, sin_r, d);
        end
      end
      BURST: begin
        q_nxt     = apply_op(mode_lat, q, sin_l, sin_r, d);
        count_nxt = count - CW'(1);
        if (count == CW'(1))
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      q        <= '0;
      count    <= '0;
      mode_lat <= M_HOLD;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      q        <= q_nxt;
      count    <= count_nxt;
      mode_lat <= mode_lat_nxt;
      busy     <= (state_nxt == BURST);
      done     <= (state_nxt == DONE);
    end
  end

  assign sout_l = q[N-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (N=8, CW=4): expected values are queued as
// each step is driven and popped for comparison one cycle later.
module tb_univ_shift_reg;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clr, en, sin_l, sin_r, start;
  logic [2:0]    mode;
  logic [N-1:0]  d;
  logic [CW-1:0] cnt;
  logic [N-1:0]  q;
  logic          sout_l, sout_r, busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        tag;
    logic [N-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];

  univ_shift_reg #(.N(N), .CW(CW)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .d(d), .start(start), .cnt(cnt), .q(q), .sout_l(sout_l), .sout_r(sout_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard: queue empty, got q=%h want an entry", q);
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (q === e.q) else begin
      errors++; $error("FAIL %s q: got %h want %h", e.tag, q, e.q);
    end
    checks++;
    assert (busy === e.busy) else begin
      errors++; $error("FAIL %s busy: got %b want %b", e.tag, busy, e.busy);
    end
    checks++;
    assert (done === e.done) else begin
      errors++; $error("FAIL %s done: got %b want %b", e.tag, done, e.done);
    end
    checks++;
    assert (sout_l === e.q[N-1]) else begin
      errors++; $error("FAIL %s sout_l: got %b want %b", e.tag, sout_l, e.q[N-1]);
    end
    checks++;
    assert (sout_r === e.q[0]) else begin
      errors++; $error("FAIL %s sout_r: got %b want %b", e.tag, sout_r, e.q[0]);
    end
  endtask

  // push expectation for the coming edge, clock it, then compare away from the edge
  task automatic step(input string tag, input logic [N-1:0] eq, input logic eb,
                      input logic ed);
    exp_t e;
    e.tag = tag; e.q = eq; e.busy = eb; e.done = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    logic [N-1:0] qm;
    clr = 1'b1; en = 1'b0; sin_l = 1'b0; sin_r = 1'b0; start = 1'b0;
    mode = 3'b000; d = '0; cnt = '0;
    #2;

    // reset, including from a non-zero q
    step("rst0", 8'h00, 1'b0, 1'b0);
    clr = 1'b0; en = 1'b1; mode = 3'b011; d = 8'h3C;
    step("pre_load", 8'h3C, 1'b0, 1'b0);
    clr = 1'b1;
    step("reset", 8'h00, 1'b0, 1'b0);
    clr = 1'b0;

    // single-step sequence
    en = 1'b1; mode = 3'b011; d = 8'hA5;
    step("ss_load", 8'hA5, 1'b0, 1'b0);
    mode = 3'b001; sin_l = 1'b1;
    step("ss_shl", 8'h4B, 1'b0, 1'b0);
    mode = 3'b010; sin_r = 1'b0;
    step("ss_shr", 8'h25, 1'b0, 1'b0);
    en = 1'b0;
    step("ss_hold", 8'h25, 1'b0, 1'b0);

    // burst rotl x3 from 0x81, stray start mid-burst and in DONE
    en = 1'b1; mode = 3'b011; d = 8'h81;
    step("ld81", 8'h81, 1'b0, 1'b0);
    en = 1'b0; start = 1'b1; mode = 3'b100; cnt = 4'd3;
    step("rotl_e0", 8'h81, 1'b1, 1'b0);
    start = 1'b1; mode = 3'b011; d = 8'hFF; cnt = 4'd1;
    step("rotl_e1", 8'h03, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000;
    step("rotl_e2", 8'h06, 1'b1, 1'b0);
    step("rotl_e3", 8'h0C, 1'b0, 1'b1);
    start = 1'b1; mode = 3'b011; d = 8'h00; cnt = 4'd1;
    step("rotl_done_start", 8'h0C, 1'b0, 1'b0);
    start = 1'b0;

    // arithmetic shifts
    en = 1'b1; mode = 3'b011; d = 8'h80;
    step("ld80", 8'h80, 1'b0, 1'b0);
    mode = 3'b110;
    step("ss_asr", 8'hC0, 1'b0, 1'b0);
    en = 1'b0; start = 1'b1; cnt = 4'd7;
    step("asr_e0", 8'hC0, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000;
    qm = 8'hC0;
    for (int i = 1; i <= 7; i++) begin
      qm = {qm[N-1], qm[N-1:1]};
      step($sformatf("asr_e%0d", i), qm, (i < 7), (i == 7));
    end
    step("asr_idle", 8'hFF, 1'b0, 1'b0);
    start = 1'b1; mode = 3'b010; cnt = 4'd10; sin_r = 1'b0;
    step("shr_e0", 8'hFF, 1'b1, 1'b0);
    start = 1'b0;
    qm = 8'hFF;
    for (int i = 1; i <= 10; i++) begin
      qm = {1'b0, qm[N-1:1]};
      step($sformatf("shr_e%0d", i), qm, (i < 10), (i == 10));
    end
    step("shr_idle", 8'h00, 1'b0, 1'b0);

    // abort by clr mid-burst
    en = 1'b1; mode = 3'b011; d = 8'hFF;
    step("ldFF", 8'hFF, 1'b0, 1'b0);
    en = 1'b0; start = 1'b1; mode = 3'b001; cnt = 4'd10; sin_l = 1'b0;
    step("abort_e0", 8'hFF, 1'b1, 1'b0);
    start = 1'b0;
    step("abort_e1", 8'hFE, 1'b1, 1'b0);
    step("abort_e2", 8'hFC, 1'b1, 1'b0);
    step("abort_e3", 8'hF8, 1'b1, 1'b0);
    clr = 1'b1;
    step("abort_e4", 8'h00, 1'b0, 1'b0);
    clr = 1'b0; start = 1'b1; mode = 3'b011; d = 8'h5A; cnt = 4'd2;
    step("restart_e0", 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    step("restart_e1", 8'h5A, 1'b0, 1'b1);
    step("restart_idle", 8'h5A, 1'b0, 1'b0);

    // degenerate bursts
    start = 1'b1; mode = 3'b001; cnt = 4'd0; sin_l = 1'b1;
    step("cnt0_e0", 8'h5A, 1'b0, 1'b1);
    start = 1'b0;
    step("cnt0_idle", 8'h5A, 1'b0, 1'b0);
    start = 1'b1; mode = 3'b011; cnt = 4'd9; d = 8'hC3;
    step("ld9_e0", 8'h5A, 1'b1, 1'b0);
    start = 1'b0;
    step("ld9_e1", 8'hC3, 1'b0, 1'b1);
    step("ld9_idle", 8'hC3, 1'b0, 1'b0);
    en = 1'b1; mode = 3'b111; d = 8'h00;
    step("rsv_ss", 8'hC3, 1'b0, 1'b0);
    mode = 3'b000;
    step("hold_ss", 8'hC3, 1'b0, 1'b0);
    en = 1'b0; start = 1'b1; mode = 3'b111; cnt = 4'd5;
    step("rsv_burst", 8'hC3, 1'b0, 1'b1);
    start = 1'b0;
    step("rsv_idle", 8'hC3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
